core_id_reg_file_mp: RTL and testbench
======================================

Name: core_id_reg_file_mp

Overview:
- Parametrised, multi-read-port integer register file for the ID stage; next generation of the 2R1W register file.
- Synchronous (registered) reads, each with its own read enable so the pipeline can hold operands during stalls.
- Write-to-read bypass, optional hardwired-zero register 0, and a post-reset clearing sweep so register contents are defined.

Parameters:
- DATA_WIDTH, 32, register width in bits.
- ADDR_WIDTH, 5, register index width; DEPTH = 2**ADDR_WIDTH entries.
- NUM_READ, 2, number of read ports (1..4).
- ZERO_REG, 1, 1 = entry 0 reads as zero and ignores writes; 0 = entry 0 is an ordinary register.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- read_addr  input  NUM_READ*ADDR_WIDTH  read addresses; port i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- read_en  input  NUM_READ  per-port read enable; bit i enables port i.
- read_data  output  NUM_READ*DATA_WIDTH  registered read data; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- write_addr  input  ADDR_WIDTH  write index.
- write_data  input  DATA_WIDTH  write value.
- write_en  input  1  write strobe.
- init_done  output  1  high once the clearing sweep has finished; the file is usable.

Behaviour:
- Reset: rst is sampled on a clock edge and is synchronous, active-high.
  - While rst is high: all read_data = 0, init_done = 0, FSM = CLEAR, clear counter = 0.
  - Array contents are not reset directly; the sweep clears them.
- FSM states:
  - CLEAR: each cycle writes 0 to entry clear counter, then increments the counter. Transitions to READY on the cycle the entry DEPTH-1 is written, so init_done rises DEPTH cycles after rst deasserts (32 for defaults).
  - READY: normal operation; stays here until rst.
  - Reset asserted mid-sweep or in READY returns to CLEAR with counter = 0.
- During CLEAR:
  - write_en is ignored; the sweep has priority.
  - read_en still updates read_data, which is forced to 0.
- Write (READY): if write_en, the array entry at write_addr takes write_data at the clock edge. When ZERO_REG=1 and write_addr == 0, the write is dropped.
- Read port i (READY), one-cycle latency:
  - if read_en[i]=0: read_data[i] holds its previous value (stall).
  - else if ZERO_REG=1 and read_addr[i] == 0: read_data[i] <= 0.
  - else if write_en and write_addr == read_addr[i] (and the write is not dropped): read_data[i] <= write_data. This is the same-cycle bypass, write-first.
  - else: read_data[i] <= array[read_addr[i]].
- Concurrency:
  - All ports are independent.
  - Any number of ports may read the same address in the same cycle; each gets the identical value.
- Widths: no arithmetic; addresses are always in range because DEPTH = 2**ADDR_WIDTH.
- Implementation: read ports may use replicated arrays or a flop array; the behaviour above is what is checked.

Test Plan:
- Reset then sweep: assert rst for 2 cycles, release; with read_en=all-1 and all addresses swept, every read returns 0. init_done goes 1 exactly 32 cycles after release.
- Basic write/read (READY): write 0xDEADBEEF to x5. Next cycle read port0 addr 5 -> read_data port0 = 0xDEADBEEF one cycle later. Port1 reading x6 returns 0.
- Bypass: in the same cycle, write_en=1, write_addr=7, write_data=0x12345678, and port0/port1 both read addr 7 -> both ports show 0x12345678 after 1 cycle (old value not returned).
- Zero register: write 0xFFFFFFFF to x0 with ZERO_REG=1. Read x0, including a same-cycle read -> 0. With ZERO_REG=0 the same sequence returns 0xFFFFFFFF.
- Stall hold: read x5 (0xDEADBEEF), then drop read_en[0] for 3 cycles while changing read_addr and writing x5 = 0x1 -> port0 holds 0xDEADBEEF. Re-enable -> port0 shows 0x1.
- Reset mid-sweep/mid-run: write x9 = 0xA5A5A5A5, assert rst 10 cycles into a later sweep or while in READY. Writes issued during CLEAR are ignored. After init_done, x9 reads 0 and init_done deasserts on the cycle after rst is sampled high.

Source files
------------

// File: rtl/core_id_reg_file_mp_if.sv
// Register-file port bundle: per-port read address/enable/data, one write port, init status.
// The master side is the ID stage and the slave side is the register file.
interface core_id_reg_file_mp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2
);
  logic [NUM_READ*ADDR_WIDTH-1:0] read_addr;
  logic [NUM_READ-1:0]            read_en;
  logic [NUM_READ*DATA_WIDTH-1:0] read_data;
  logic [ADDR_WIDTH-1:0]          write_addr;
  logic [DATA_WIDTH-1:0]          write_data;
  logic                           write_en;
  logic                           init_done;

  modport master (
    output read_addr, read_en, write_addr, write_data, write_en,
    input  read_data, init_done
  );

  modport slave (
    input  read_addr, read_en, write_addr, write_data, write_en,
    output read_data, init_done
  );
endinterface

// File: rtl/core_id_reg_file_mp.sv
// Multi-read-port ID-stage register file: registered reads with per-port hold, write-first
// bypass, optional hardwired-zero x0, and a post-reset sweep that zeroes every entry.
module core_id_reg_file_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int ZERO_REG   = 1
) (
  input logic                   clk,
  input logic                   rst,
  core_id_reg_file_mp_if.slave  bus
);
  localparam int DEPTH    = 2 ** ADDR_WIDTH;
  localparam bit HAS_ZERO = (ZERO_REG != 0);

  typedef enum logic {CLEAR, READY} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DATA_WIDTH-1:0]   rd_next [NUM_READ];
  logic                    wr_ok;

  // A write to x0 is dropped when x0 is hardwired, so it must not feed the bypass either.
  assign wr_ok = bus.write_en && !(HAS_ZERO && (bus.write_addr == '0));

  // NOTE: every variable assigned in always_comb gets a value on every path, or a latch is inferred.
  always_comb begin
    for (int i = 0; i < NUM_READ; i++) begin
      rd_next[i] = mem[bus.read_addr[i*ADDR_WIDTH +: ADDR_WIDTH]];
      if (HAS_ZERO && (bus.read_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == '0))
        rd_next[i] = '0;
      else if (wr_ok && (bus.write_addr == bus.read_addr[i*ADDR_WIDTH +: ADDR_WIDTH]))
        rd_next[i] = bus.write_data;
    end
  end

  // NOTE: the storage array has no reset term; the clearing sweep defines its contents,
  // which keeps it mappable onto plain flops or RAM without a wide reset fan-out.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR)
        mem[clr_cnt] <= '0;
      else if (wr_ok)
        mem[bus.write_addr] <= bus.write_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= CLEAR;
      clr_cnt       <= '0;
      bus.init_done <= 1'b0;
      bus.read_data <= '0;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          for (int i = 0; i < NUM_READ; i++)
            if (bus.read_en[i]) bus.read_data[i*DATA_WIDTH +: DATA_WIDTH] <= '0;
          if (&clr_cnt) begin
            state         <= READY;
            bus.init_done <= 1'b1;
          end
        end
        READY: begin
          for (int i = 0; i < NUM_READ; i++)
            if (bus.read_en[i]) bus.read_data[i*DATA_WIDTH +: DATA_WIDTH] <= rd_next[i];
        end
        default: state <= CLEAR;
      endcase
    end
  end
endmodule

// File: tb/tb_core_id_reg_file_mp.sv
// Self-checking bench: two register files (x0 hardwired / x0 ordinary) share one stimulus
// stream and are compared every cycle against a behavioural model plus literal checkpoints.
module tb_core_id_reg_file_mp;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 2 ** AW;

  logic clk = 1'b0;
  logic rst;
  logic [NR*AW-1:0] read_addr;
  logic [NR-1:0]    read_en;
  logic [AW-1:0]    write_addr;
  logic [DW-1:0]    write_data;
  logic             write_en;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: index 0 = ZERO_REG=1 instance, index 1 = ZERO_REG=0 instance.
  logic [DW-1:0] mem    [2][DEPTH];
  logic [DW-1:0] exp_rd [2][NR];
  logic          exp_init [2];
  int            rel_cnt;

  always #5 clk = ~clk;

  core_id_reg_file_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR)) bus_z ();
  core_id_reg_file_mp_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR)) bus_n ();

  assign bus_z.read_addr  = read_addr;
  assign bus_z.read_en    = read_en;
  assign bus_z.write_addr = write_addr;
  assign bus_z.write_data = write_data;
  assign bus_z.write_en   = write_en;
  assign bus_n.read_addr  = read_addr;
  assign bus_n.read_en    = read_en;
  assign bus_n.write_addr = write_addr;
  assign bus_n.write_data = write_data;
  assign bus_n.write_en   = write_en;

  core_id_reg_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .ZERO_REG(1)) dut_z (
    .clk (clk),
    .rst (rst),
    .bus (bus_z.slave)
  );

  core_id_reg_file_mp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR), .ZERO_REG(0)) dut_n (
    .clk (clk),
    .rst (rst),
    .bus (bus_n.slave)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rd(input int d, input int p);
    return (d == 0) ? bus_z.read_data[p*DW +: DW] : bus_n.read_data[p*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] init_of(input int d);
    return (d == 0) ? DW'(bus_z.init_done) : DW'(bus_n.init_done);
  endfunction

  // Behavioural model: the file is unusable for DEPTH edges after release, during which
  // the edge k after release zeroes entry k-1; afterwards reads see write-first data.
  task automatic model_update();
    logic          hit;
    logic [AW-1:0] a;
    if (rst) begin
      rel_cnt = 0;
      for (int d = 0; d < 2; d++) begin
        exp_init[d] = 1'b0;
        for (int p = 0; p < NR; p++) exp_rd[d][p] = '0;
      end
    end else if (rel_cnt < DEPTH) begin
      for (int d = 0; d < 2; d++) begin
        mem[d][rel_cnt] = '0;
        for (int p = 0; p < NR; p++) if (read_en[p]) exp_rd[d][p] = '0;
      end
      rel_cnt++;
      for (int d = 0; d < 2; d++) exp_init[d] = (rel_cnt == DEPTH);
    end else begin
      for (int d = 0; d < 2; d++) begin
        hit = write_en && !((d == 0) && (write_addr == '0));
        for (int p = 0; p < NR; p++) begin
          if (read_en[p]) begin
            a = read_addr[p*AW +: AW];
            if ((d == 0) && (a == '0))          exp_rd[d][p] = '0;
            else if (hit && (write_addr == a))  exp_rd[d][p] = write_data;
            else                                exp_rd[d][p] = mem[d][a];
          end
        end
        if (hit) mem[d][write_addr] = write_data;
      end
    end
  endtask

  task automatic compare();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("model dut%0d init_done", d), init_of(d), DW'(exp_init[d]));
      for (int p = 0; p < NR; p++)
        check($sformatf("model dut%0d rd%0d", d, p), rd(d, p), exp_rd[d][p]);
    end
  endtask

  // One clock: inputs are already set; model advances at the edge, outputs checked at negedge.
  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
  endtask

  task automatic set_idle();
    read_en    = '0;
    read_addr  = '0;
    write_en   = 1'b0;
    write_addr = '0;
    write_data = '0;
  endtask

  task automatic set_read(input int p, input int addr, input logic en);
    read_addr[p*AW +: AW] = AW'(addr);
    read_en[p]            = en;
  endtask

  task automatic set_write(input logic en, input int addr, input logic [DW-1:0] data);
    write_en   = en;
    write_addr = AW'(addr);
    write_data = data;
  endtask

  initial begin
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < DEPTH; i++) mem[d][i] = '0;
    rel_cnt = 0;
    rst = 1'b1;
    set_idle();

    // Reset for two cycles.
    cycle();
    cycle();
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset dut%0d init_done", d), init_of(d), '0);
      check($sformatf("reset dut%0d rd0", d), rd(d, 0), '0);
    end

    // Release and sweep: all reads zero, init_done rises on exactly the 32nd edge.
    rst = 1'b0;
    for (int c = 1; c <= DEPTH; c++) begin
      set_read(0, c - 1, 1'b1);
      set_read(1, DEPTH - c, 1'b1);
      cycle();
      check("sweep init_done", init_of(0), DW'(c == DEPTH));
      check("sweep rd1", rd(1, 1), '0);
    end

    // Basic write then read.
    set_idle();
    set_write(1'b1, 5, 32'hDEADBEEF);
    cycle();
    set_write(1'b0, 0, '0);
    set_read(0, 5, 1'b1);
    set_read(1, 6, 1'b1);
    cycle();
    check("basic x5", rd(0, 0), 32'hDEADBEEF);
    check("basic x6", rd(0, 1), 32'h0);

    // Bypass: old x7 value must not come back.
    set_idle();
    set_write(1'b1, 7, 32'h11111111);
    cycle();
    set_write(1'b1, 7, 32'h12345678);
    set_read(0, 7, 1'b1);
    set_read(1, 7, 1'b1);
    cycle();
    check("bypass p0", rd(0, 0), 32'h12345678);
    check("bypass p1", rd(1, 1), 32'h12345678);

    // x0: dropped on the hardwired instance, ordinary on the other.
    set_write(1'b1, 0, 32'hFFFFFFFF);
    set_read(0, 0, 1'b1);
    set_read(1, 0, 1'b1);
    cycle();
    check("zero same-cycle z", rd(0, 1), 32'h0);
    check("zero same-cycle n", rd(1, 1), 32'hFFFFFFFF);
    set_write(1'b0, 0, '0);
    cycle();
    check("zero later z", rd(0, 0), 32'h0);
    check("zero later n", rd(1, 0), 32'hFFFFFFFF);

    // Stall hold on port 0 while the address changes and x5 is rewritten.
    set_idle();
    set_read(0, 5, 1'b1);
    cycle();
    check("stall pre", rd(0, 0), 32'hDEADBEEF);
    for (int k = 0; k < 3; k++) begin
      set_read(0, 10 + k, 1'b0);
      set_write(k == 0, 5, 32'h1);
      cycle();
      check("stall hold", rd(0, 0), 32'hDEADBEEF);
    end
    set_write(1'b0, 0, '0);
    set_read(0, 5, 1'b1);
    cycle();
    check("stall release", rd(1, 0), 32'h1);

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 500; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int p = 0; p < NR; p++)
        set_read(p, $urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, DEPTH - 1),
                 1'($urandom_range(0, 3) != 0));
      set_write(1'($urandom_range(0, 1)),
                $urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, DEPTH - 1),
                $urandom());
      cycle();
    end

    // Reset in READY and mid-sweep; writes during CLEAR are ignored.
    set_idle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int c = 1; c <= DEPTH; c++) begin
      set_write(1'b1, $urandom_range(0, DEPTH - 1), $urandom());
      cycle();
    end
    check("resweep init_done", init_of(1), 32'h1);
    set_idle();
    set_write(1'b1, 9, 32'hA5A5A5A5);
    cycle();
    set_write(1'b0, 0, '0);
    set_read(1, 9, 1'b1);
    cycle();
    check("x9 written", rd(0, 1), 32'hA5A5A5A5);
    set_idle();
    rst = 1'b1;
    cycle();
    check("ready rst init_done", init_of(0), 32'h0);
    check("ready rst rd1", rd(1, 1), 32'h0);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      set_write(1'b1, 9, 32'hCAFE0000 + c);
      cycle();
    end
    rst = 1'b1;
    cycle();
    check("midsweep rst init_done", init_of(1), 32'h0);
    rst = 1'b0;
    for (int c = 1; c <= DEPTH; c++) begin
      set_write(1'b1, 9, 32'hBEEF0000 + c);
      cycle();
      check("final sweep init_done", init_of(0), DW'(c == DEPTH));
    end
    set_idle();
    set_read(0, 9, 1'b1);
    set_read(1, 9, 1'b1);
    cycle();
    check("x9 cleared z", rd(0, 0), 32'h0);
    check("x9 cleared n", rd(1, 1), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
